// File: rtl/interrupt_ctrl.sv
// Four-source vectored interrupt controller: rising-edge capture, mask/vector config,
// fixed priority (source 0 highest), single-level service with RETI handshake.
module interrupt_ctrl #(
    parameter int          NIRQ    = 4,
    parameter logic [7:0]  VEC_DEF = 8'hF0
) (
    input  logic            CK,
    input  logic            RST_N,
    input  logic [NIRQ-1:0] IRQ,
    input  logic [7:0]      BUS,
    input  logic            CFG_LD,
    input  logic [2:0]      CFG_SEL,
    input  logic [7:0]      PC_AD,
    input  logic            RETI,
    output logic            EVENT,
    output logic [7:0]      VEC,
    output logic [7:0]      RET_AD,
    output logic            BUSY,
    output logic [NIRQ-1:0] PEND
);

    typedef enum logic [1:0] {
        IDLE,
        FIRE,
        SERVICE
    } state_t;

    state_t          state;
    logic [NIRQ-1:0] irq_q;
    logic [NIRQ-1:0] mask;
    logic [7:0]      vect [NIRQ];

    logic [NIRQ-1:0] rise;
    logic [NIRQ-1:0] eligible;
    logic [NIRQ-1:0] win_onehot;
    logic [7:0]      win_vec;
    logic            found;

    always_comb begin
        rise = IRQ & ~irq_q;
        for (int i = 0; i < NIRQ; i++) begin
            eligible[i] = PEND[i] & mask[i] & (vect[i] != 8'h00);
        end
    end

    // Scan from the highest index down so the lowest eligible index is the last writer.
    always_comb begin
        win_onehot = '0;
        win_vec    = 8'h00;
        found      = |eligible;
        for (int i = NIRQ - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                win_onehot    = '0;
                win_onehot[i] = 1'b1;
                win_vec       = vect[i];
            end
        end
    end

    always_ff @(posedge CK) begin
        if (!RST_N) begin
            state  <= IDLE;
            EVENT  <= 1'b0;
            VEC    <= 8'h00;
            RET_AD <= 8'h00;
            BUSY   <= 1'b0;
            PEND   <= '0;
            mask   <= '0;
            irq_q  <= '0;
            for (int i = 0; i < NIRQ; i++) begin
                vect[i] <= VEC_DEF + 8'(4 * i);
            end
        end else begin
            irq_q <= IRQ;
            PEND  <= PEND | rise;

            case (state)
                IDLE: begin
                    if (found) begin
                        state  <= FIRE;
                        EVENT  <= 1'b1;
                        BUSY   <= 1'b1;
                        VEC    <= win_vec;
                        RET_AD <= PC_AD + 8'd1;
                        // A fresh edge on the winner's own line re-arms it.
                        PEND   <= (PEND & ~win_onehot) | rise;
                    end
                end
                FIRE: begin
                    state <= SERVICE;
                    EVENT <= 1'b0;
                end
                SERVICE: begin
                    if (RETI) begin
                        state <= IDLE;
                        BUSY  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    EVENT <= 1'b0;
                    BUSY  <= 1'b0;
                end
            endcase

            if (CFG_LD) begin
                if (CFG_SEL == 3'd4) begin
                    mask <= BUS[NIRQ-1:0];
                end else if (CFG_SEL < 3'(NIRQ)) begin
                    vect[CFG_SEL[1:0]] <= BUS;
                end
            end
        end
    end

endmodule
